freq_meas_ctrl: RTL and testbench
=================================

FREQ_MEAS_CTRL -- requirements
Module: freq_meas_ctrl

Interface
REQ-001 SHALL have parameter PLL_FREQ, default 200_000_000, pll_clk frequency in Hz (informational; passed to software).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 200_000_000, maximum pll_clk cycles per measurement window before abort (1 s).
REQ-003 SHALL have ports pll_clk  in  1  measurement clock; sys_rst_n  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports start  in  1  one-cycle request; abort  in  1  cancel; continuous  in  1  back-to-back windows.
REQ-005 SHALL have ports wave_in  in  1  asynchronous square wave; n_cfg  in  16  periods per window.
REQ-006 SHALL have ports busy  out  1  window armed or open; done  out  1  one-cycle result strobe; timeout  out  1  one-cycle timeout strobe.
REQ-007 SHALL have ports ref_cnt  out  32  window length in pll_clk cycles; high_cnt  out  32  cycles with wave high inside the window; n_used  out  16  periods measured.

Function
REQ-008 SHALL synchronise wave_in through two flops (s1, s2) plus a delay flop s3; rise = s2 & ~s3.
REQ-009 SHALL implement FSM IDLE, ARM, GATE; busy = (state != IDLE).
REQ-010 IDLE: start -> ARM; latch n_lat = n_cfg (0 treated as 1) and cont_lat = continuous; clear timeout counter.
REQ-011 ARM: on rise -> GATE, ref_acc <= 1, edge_acc <= 0, high_acc <= s2 (1).
REQ-012 GATE: each cycle without terminating rise: ref_acc += 1, high_acc += s2; on each rise edge_acc += 1.
REQ-013 Terminating rise: rise while edge_acc == n_lat-1; ref_acc/high_acc are NOT incremented that cycle; ref_cnt <= ref_acc, high_cnt <= high_acc, n_used <= n_lat; done = 1 next cycle for exactly one cycle.
REQ-014 After termination: if cont_lat && continuous, stay in GATE with terminating edge as new first edge (ref_acc <= 1, edge_acc <= 0, high_acc <= 1, timeout counter cleared, n_lat <= n_cfg); else -> IDLE.
REQ-015 Timeout counter increments in ARM and GATE; on reaching TIMEOUT_CYC-1 -> IDLE, timeout = 1 next cycle for one cycle, result outputs unchanged, no done.
REQ-016 abort in ARM/GATE -> IDLE next cycle, no done, no timeout, results unchanged; abort has priority over termination and timeout in the same cycle.
REQ-017 start while busy SHALL be ignored; start and abort together in IDLE: stay IDLE.
REQ-018 ref_cnt, high_cnt, n_used SHALL hold between done strobes; accumulators are 32 bit, never wrap because TIMEOUT_CYC < 2^32.
REQ-019 Termination and timeout in the same cycle: termination wins (done, not timeout).

Reset
REQ-020 While sys_rst_n = 1: state IDLE, busy 0, done 0, timeout 0, ref_cnt 0, high_cnt 0, n_used 0, all accumulators and sync flops 0.
REQ-021 Reset asserted mid-window SHALL discard the window with no done or timeout strobe after release.

Configuration
REQ-022 Macro DUTY_MEAS_EN: defined -> high_acc/high_cnt operate per REQ-011..013; undefined -> high_acc logic absent, high_cnt tied to 0, port retained.

Structure
REQ-023 Package freq_meas_pkg SHALL hold the FSM state type, CNT_W = 32, N_W = 16.
REQ-024 Sub-module freq_meas_edge_sync SHALL contain s1/s2/s3 and rise detection, outputs s2 and rise.

Verification
REQ-025 Period 100 cycles, high 30, n_cfg 4, start -> one done; ref_cnt 400, high_cnt 120 (0 without DUTY_MEAS_EN), n_used 4, then busy 0.
REQ-026 n_cfg 0, period 50 -> ref_cnt 50, n_used 1.
REQ-027 continuous 1, period 80, n_cfg 2 -> done every 160 cycles, each ref_cnt 160, no gap; drop continuous -> FSM idles after next done.
REQ-028 wave_in static, TIMEOUT_CYC 1000 -> timeout strobe 1000 cycles after start, results unchanged, busy 0.
REQ-029 abort 10 cycles into GATE -> IDLE next cycle, no done; start during busy ignored.
REQ-030 Assert sys_rst_n mid-GATE -> all outputs 0, no strobe after release.

Source files
------------

// File: rtl/freq_meas_pkg.sv
// Shared types and widths for the frequency/duty measurement controller.
package freq_meas_pkg;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned N_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2
  } state_t;

  // A zero period count would never terminate a window, so it means one period.
  function automatic logic [N_W-1:0] n_clamp(input logic [N_W-1:0] n);
    return (n == '0) ? N_W'(1) : n;
  endfunction

endpackage

// File: rtl/freq_meas_ctrl_if.sv
// Control/result bundle of freq_meas_ctrl; master = software side, slave = controller.
interface freq_meas_ctrl_if;
  import freq_meas_pkg::*;

  logic             start;
  logic             abort;
  logic             continuous;
  logic [N_W-1:0]   n_cfg;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] ref_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [N_W-1:0]   n_used;

  modport master (
    output start, abort, continuous, n_cfg,
    input  busy, done, timeout, ref_cnt, high_cnt, n_used
  );

  modport slave (
    input  start, abort, continuous, n_cfg,
    output busy, done, timeout, ref_cnt, high_cnt, n_used
  );

endinterface

// File: rtl/freq_meas_edge_sync.sv
// Two-flop synchroniser for the measured wave plus a delay flop for rising-edge detection.
module freq_meas_edge_sync (
  input  logic pll_clk,
  input  logic sys_rst_n,
  input  logic wave_in,
  output logic s2,
  output logic rise
);

  // bit 0 = s1, bit 1 = s2, bit 2 = s3
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], wave_in};
  end

  always_ff @(posedge pll_clk or posedge sys_rst_n) begin
    if (sys_rst_n) sync_q <= '0;
    else           sync_q <= sync_d;
  end

  assign s2   = sync_q[1];
  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/freq_meas_ctrl.sv
// Gated period/duty measurement of an asynchronous square wave against pll_clk.
// Optional duty-cycle accumulation is built only when DUTY_MEAS_EN is defined.
module freq_meas_ctrl
  import freq_meas_pkg::*;
#(
  parameter int unsigned PLL_FREQ    = 200_000_000,
  parameter int unsigned TIMEOUT_CYC = 200_000_000
) (
  input  logic              pll_clk,
  input  logic              sys_rst_n,
  input  logic              wave_in,
  freq_meas_ctrl_if.slave   ctl
);

  if (PLL_FREQ == 0 || TIMEOUT_CYC == 0) begin : g_bad_cfg
    $error("freq_meas_ctrl: PLL_FREQ and TIMEOUT_CYC must be nonzero");
  end

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic wave_rise;
`ifdef DUTY_MEAS_EN
  logic wave_s2;
  freq_meas_edge_sync u_sync (
    .pll_clk   (pll_clk),
    .sys_rst_n (sys_rst_n),
    .wave_in   (wave_in),
    .s2        (wave_s2),
    .rise      (wave_rise)
  );
`else
  freq_meas_edge_sync u_sync (
    .pll_clk   (pll_clk),
    .sys_rst_n (sys_rst_n),
    .wave_in   (wave_in),
    .s2        (),
    .rise      (wave_rise)
  );
`endif

  state_t           state_q, state_d;
  logic [N_W-1:0]   n_lat_q, n_lat_d;
  logic             cont_lat_q, cont_lat_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] ref_acc_q, ref_acc_d;
  logic [N_W-1:0]   edge_acc_q, edge_acc_d;
  logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
  logic [N_W-1:0]   n_used_q, n_used_d;

  logic to_hit, last_edge;
  logic win_open, win_step, win_close;

  assign to_hit    = (to_cnt_q == TO_LAST);
  assign last_edge = wave_rise && (edge_acc_q == n_lat_q - N_W'(1));

  // Priority inside ARM/GATE: abort, then termination, then timeout.
  always_comb begin
    state_d    = state_q;
    n_lat_d    = n_lat_q;
    cont_lat_d = cont_lat_q;
    to_cnt_d   = to_cnt_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    win_open   = 1'b0;
    win_step   = 1'b0;
    win_close  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ctl.start && !ctl.abort) begin
          state_d    = ARM;
          n_lat_d    = n_clamp(ctl.n_cfg);
          cont_lat_d = ctl.continuous;
          to_cnt_d   = '0;
        end
      end
      ARM: begin
        to_cnt_d = to_cnt_q + CNT_W'(1);
        if (ctl.abort) begin
          state_d = IDLE;
        end else if (to_hit) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else if (wave_rise) begin
          state_d  = GATE;
          win_open = 1'b1;
        end
      end
      GATE: begin
        to_cnt_d = to_cnt_q + CNT_W'(1);
        if (ctl.abort) begin
          state_d = IDLE;
        end else if (last_edge) begin
          win_close = 1'b1;
          done_d    = 1'b1;
          if (cont_lat_q && ctl.continuous) begin
            win_open = 1'b1;
            to_cnt_d = '0;
            n_lat_d  = n_clamp(ctl.n_cfg);
          end else begin
            state_d = IDLE;
          end
        end else if (to_hit) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          win_step = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pll_clk or posedge sys_rst_n) begin
    if (sys_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Closing latches the old accumulators before a continuous restart reloads them.
  always_comb begin
    ref_acc_d  = ref_acc_q;
    edge_acc_d = edge_acc_q;
    ref_cnt_d  = ref_cnt_q;
    n_used_d   = n_used_q;
    if (win_close) begin
      ref_cnt_d = ref_acc_q;
      n_used_d  = n_lat_q;
    end
    if (win_open) begin
      ref_acc_d  = CNT_W'(1);
      edge_acc_d = '0;
    end else if (win_step) begin
      ref_acc_d = ref_acc_q + CNT_W'(1);
      if (wave_rise) edge_acc_d = edge_acc_q + N_W'(1);
    end
  end

  always_ff @(posedge pll_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      n_lat_q    <= '0;
      cont_lat_q <= 1'b0;
      to_cnt_q   <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ref_acc_q  <= '0;
      edge_acc_q <= '0;
      ref_cnt_q  <= '0;
      n_used_q   <= '0;
    end else begin
      n_lat_q    <= n_lat_d;
      cont_lat_q <= cont_lat_d;
      to_cnt_q   <= to_cnt_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      ref_acc_q  <= ref_acc_d;
      edge_acc_q <= edge_acc_d;
      ref_cnt_q  <= ref_cnt_d;
      n_used_q   <= n_used_d;
    end
  end

`ifdef DUTY_MEAS_EN
  logic [CNT_W-1:0] high_acc_q, high_acc_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;

  always_comb begin
    high_acc_d = high_acc_q;
    high_cnt_d = high_cnt_q;
    if (win_close) high_cnt_d = high_acc_q;
    if (win_open)      high_acc_d = CNT_W'(wave_s2);
    else if (win_step) high_acc_d = high_acc_q + CNT_W'(wave_s2);
  end

  always_ff @(posedge pll_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      high_acc_q <= '0;
      high_cnt_q <= '0;
    end else begin
      high_acc_q <= high_acc_d;
      high_cnt_q <= high_cnt_d;
    end
  end

  assign ctl.high_cnt = high_cnt_q;
`else
  assign ctl.high_cnt = '0;
`endif

  assign ctl.busy    = (state_q != IDLE);
  assign ctl.done    = done_q;
  assign ctl.timeout = timeout_q;
  assign ctl.ref_cnt = ref_cnt_q;
  assign ctl.n_used  = n_used_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed self-checking bench for freq_meas_ctrl with a cycle-exact square-wave source.
`timescale 1ns/1ps
module tb_freq_meas_ctrl;
  import freq_meas_pkg::*;

  localparam int unsigned TO_CYC = 1000;
`ifdef DUTY_MEAS_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic pll_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  logic wave_in   = 1'b0;

  freq_meas_ctrl_if bus ();

  freq_meas_ctrl #(
    .PLL_FREQ    (200_000_000),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .pll_clk   (pll_clk),
    .sys_rst_n (sys_rst_n),
    .wave_in   (wave_in),
    .ctl       (bus)
  );

  always #5 pll_clk = ~pll_clk;

  int unsigned cyc = 0;
  always @(posedge pll_clk) cyc <= cyc + 1;

  // Strobe counters sampled 1 ns after the active edge.
  int unsigned n_done = 0;
  int unsigned n_to   = 0;
  initial begin
    forever begin
      @(posedge pll_clk);
      #1;
      if (bus.done)    n_done++;
      if (bus.timeout) n_to++;
    end
  end

  // Wave source: wave_hi cycles high out of every wave_per, phase 0 high.
  bit          wave_en  = 1'b0;
  int unsigned wave_per = 100;
  int unsigned wave_hi  = 30;
  int unsigned wave_ph  = 0;
  initial begin
    forever begin
      @(negedge pll_clk);
      if (wave_en) begin
        wave_in = (wave_ph < wave_hi);
        wave_ph = (wave_ph + 1 == wave_per) ? 0 : wave_ph + 1;
      end else begin
        wave_in = 1'b0;
        wave_ph = 0;
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge pll_clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic set_wave(input int unsigned per, input int unsigned hi);
    wave_en = 1'b0;
    tick(3);
    wave_per = per;
    wave_hi  = hi;
    wave_en  = 1'b1;
  endtask

  task automatic wait_strobe(input bit want_to, input int unsigned max_cyc, output bit seen);
    seen = 1'b0;
    for (int unsigned i = 0; i < max_cyc && !seen; i++) begin
      @(negedge pll_clk);
      seen = want_to ? bus.timeout : bus.done;
    end
  endtask

  bit          seen;
  int unsigned t0, nd0, nt0;

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.continuous = 1'b0;
    bus.n_cfg      = 16'd4;

    // Reset values
    tick(4);
    chk("rst_busy",    32'(bus.busy), 0);
    chk("rst_done",    32'(bus.done), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    chk("rst_ref",     bus.ref_cnt, 0);
    chk("rst_high",    bus.high_cnt, 0);
    chk("rst_nused",   32'(bus.n_used), 0);
    sys_rst_n = 1'b0;
    tick(3);

    // A: 100-cycle period, 30 high, four periods; a start while busy is ignored
    set_wave(100, 30);
    bus.n_cfg = 16'd4;
    pulse_start();
    tick(150);
    chk("a_busy", 32'(bus.busy), 1);
    bus.n_cfg = 16'd1;
    pulse_start();
    bus.n_cfg = 16'd4;
    wait_strobe(1'b0, 800, seen);
    chk("a_done_seen", 32'(seen), 1);
    chk("a_ref",   bus.ref_cnt, 400);
    chk("a_high",  bus.high_cnt, DUTY ? 120 : 0);
    chk("a_nused", 32'(bus.n_used), 4);
    tick(1);
    chk("a_done_1cyc", 32'(bus.done), 0);
    chk("a_idle",      32'(bus.busy), 0);

    // B: n_cfg 0 means one period
    set_wave(50, 25);
    bus.n_cfg = 16'd0;
    pulse_start();
    chk("b_hold_ref", bus.ref_cnt, 400);
    wait_strobe(1'b0, 300, seen);
    chk("b_done_seen", 32'(seen), 1);
    chk("b_ref",   bus.ref_cnt, 50);
    chk("b_high",  bus.high_cnt, DUTY ? 25 : 0);
    chk("b_nused", 32'(bus.n_used), 1);

    // C: continuous windows of 2 x 80 cycles, back to back
    set_wave(80, 40);
    bus.n_cfg      = 16'd2;
    bus.continuous = 1'b1;
    pulse_start();
    wait_strobe(1'b0, 400, seen);
    chk("c_first_seen", 32'(seen), 1);
    for (int k = 0; k < 2; k++) begin
      t0 = cyc;
      wait_strobe(1'b0, 300, seen);
      chk("c_seen",   32'(seen), 1);
      chk("c_period", cyc - t0, 160);
      chk("c_ref",    bus.ref_cnt, 160);
      chk("c_high",   bus.high_cnt, DUTY ? 80 : 0);
      chk("c_nused",  32'(bus.n_used), 2);
      chk("c_busy",   32'(bus.busy), 1);
    end
    bus.continuous = 1'b0;
    t0 = cyc;
    wait_strobe(1'b0, 300, seen);
    chk("c_last_seen",   32'(seen), 1);
    chk("c_last_period", cyc - t0, 160);
    chk("c_last_idle",   32'(bus.busy), 0);
    tick(1);
    chk("c_done_1cyc", 32'(bus.done), 0);

    // D: static wave, timeout 1000 cycles after the edge that samples start
    wave_en = 1'b0;
    tick(5);
    nd0 = n_done;
    bus.n_cfg = 16'd4;
    t0 = cyc + 1;
    pulse_start();
    wait_strobe(1'b1, 1100, seen);
    chk("d_to_seen",  32'(seen), 1);
    chk("d_to_time",  cyc - t0, TO_CYC);
    chk("d_idle",     32'(bus.busy), 0);
    chk("d_ref_hold", bus.ref_cnt, 160);
    chk("d_n_hold",   32'(bus.n_used), 2);
    tick(1);
    chk("d_to_1cyc",  32'(bus.timeout), 0);
    chk("d_no_done",  n_done - nd0, 0);

    // E: abort inside GATE, then start+abort together in IDLE
    set_wave(100, 50);
    pulse_start();
    tick(12);
    chk("e_busy", 32'(bus.busy), 1);
    nd0 = n_done;
    nt0 = n_to;
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    chk("e_abort_idle", 32'(bus.busy), 0);
    tick(1100);
    chk("e_no_done",  n_done - nd0, 0);
    chk("e_no_to",    n_to - nt0, 0);
    chk("e_ref_hold", bus.ref_cnt, 160);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick(1);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("e_start_abort_idle", 32'(bus.busy), 0);

    // F: reset mid-window discards it
    pulse_start();
    tick(50);
    chk("f_busy", 32'(bus.busy), 1);
    nd0 = n_done;
    nt0 = n_to;
    sys_rst_n = 1'b1;
    tick(2);
    chk("f_rst_busy",  32'(bus.busy), 0);
    chk("f_rst_ref",   bus.ref_cnt, 0);
    chk("f_rst_high",  bus.high_cnt, 0);
    chk("f_rst_nused", 32'(bus.n_used), 0);
    chk("f_rst_done",  32'(bus.done), 0);
    chk("f_rst_to",    32'(bus.timeout), 0);
    sys_rst_n = 1'b0;
    tick(1100);
    chk("f_no_done", n_done - nd0, 0);
    chk("f_no_to",   n_to - nt0, 0);
    chk("f_idle",    32'(bus.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
